vec_alu_lane: RTL and testbench
===============================

# vec_alu_lane

Single-lane vector integer ALU slice for the RVV vector unit, VLEN = 128. It applies one element-wise operation, selected by a funct6-style opcode, to two 128-bit source registers. Work proceeds one chunk per cycle while `run` is high, and `done` is raised once this lane's share of the register has been computed. Several instances (lanes) can split a register; lane `LANE_I` of `2^NB_LANES` lanes owns every `2^NB_LANES`-th chunk.

## Interface
- `NB_LANES`, default 2'b00: log2 of lane count (00→1, 01→2, 10→4, 11→8).
- `LANE_I`, default 3'b000: index of this lane; must be < 2^NB_LANES.
- `clk` in 1: the single clock; all state updates on rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `opcode` in 6: operation select (funct6 encoding).
- `run` in 1: 1 = advance one chunk per cycle; 0 = synchronous clear/restart.
- `vs1` in 128: source operand 1; element k at bits [k*SEW +: SEW].
- `vs2` in 128: source operand 2, same layout.
- `vsew` in 3: element width; 000=8, 001=16, 010=32, 011=64 bits; 1xx reserved.
- `vd` out 128: result register.
- `done` out 1: this lane's chunks are all written to `vd`.

## Operation
- Opcodes:
  - 000000 vadd: vs2+vs1, wrapping.
  - 000010 vsub: vs2−vs1, wrapping.
  - 001001 vand.
  - 001010 vor.
  - 001011 vxor.
  - Any other opcode writes zeros to the chunk.
- Chunk width C = min(SEW, 32). Total chunks N = 128/C: 16 / 8 / 4 / 4 for SEW 8 / 16 / 32 / 64.
- This lane processes chunks j = LANE_I + i·2^NB_LANES, in increasing i. Its count is M = N / 2^NB_LANES.
- Processing chunk j writes `vd[j*C +: C]` = op(`vs2` chunk, `vs1` chunk). Bits not owned by this lane stay 0.
- Element independence: no carry or borrow crosses an element boundary. For 8/16/32-bit elements, the sum simply wraps.
- SEW=64: each element is two 32-bit chunks, low chunk first. A carry/borrow register holds the low-half carry-out (add) or borrow (sub) for the high half. It is cleared at every element start.
  - For SEW=64 with more than one lane, the lane count is forced to pair chunks: lane chunk order stays low/high per element. Configurations where a lane does not own both halves of an element are unsupported.
- Reserved `vsew` (1xx): `done` rises after the first run cycle, and `vd` stays 0.
- Inputs are sampled every cycle. They must be held stable while `run`=1.

## Timing
- Reset (`resetn`=0, async): `vd`=0, `done`=0, chunk counter=0, carry=0.
- Clock edge with `run`=0: counter=0, carry=0, `vd`=0, `done`=0.
- Clock edge with `run`=1 and `done`=0: write the current chunk and increment the counter. After the M-th such edge, `done`=1.
  - So `done` is 0 after run edges 1..M−1 and 1 after edge M. Latency is M cycles: 16/8/4/4 for one lane.
- While `run`=1 and `done`=1: `vd` and `done` hold.
- A new operation requires at least one edge with `run`=0 first.
- Deasserting `run` mid-operation aborts: the next edge clears everything.
- Asserting `resetn` mid-operation clears immediately, without waiting for a clock edge.

## Structure
- Shared package `vec_alu_pkg`: VLEN=128, CHUNK_MAX=32, opcode constants (OP_VADD, OP_VSUB, OP_VAND, OP_VOR, OP_VXOR), and vsew encodings.
- Sub-module `vec_alu_chunk`: a combinational 32-bit slice.
  - Inputs: a, b, opcode, width C, carry-in.
  - Outputs: result, carry-out.
  - Arithmetic is segmented at 8/16-bit boundaries, so no carry crosses a sub-element boundary.
- The top level holds the counter, the chunk mux/demux, the carry register, and the `vd`/`done` registers.

## Test plan
- vand, single lane, vs1=abcdabcdbeefbeef1234567887654321, vs2=8765432112345678beefbeefabcdabcd, SEW=8:
  - Stimulus: one `run`=0 edge, then 16 `run`=1 edges.
  - Required: `done`=0 after edges 1–15, `done`=1 after edge 16, `vd`=83450301122416681224166883450301.
- Same operands, SEW=16 / 32 / 64 → same `vd`, with `done` first high after edge 8 / 4 / 4 respectively.
- vadd, SEW=8, every byte 0xFF + 0x01 → `vd`=0 (no inter-element carry).
- vadd, SEW=64, vs1 low element 0x00000000FFFFFFFF, vs2 low element 0x1 → `vd` low element 0x0000000100000000 (carry crosses halves). Also check vsub 0x0000000100000000−0x1 → 0x00000000FFFFFFFF.
- NB_LANES=01, LANE_I=1, vand, SEW=32:
  - `done` after 2 edges.
  - `vd` chunks 1 and 3 = AND results; chunks 0 and 2 = 0.
- Abort/reset:
  - Drop `run` after 5 edges (SEW=8): the next edge gives `vd`=0, `done`=0.
  - Pulse `resetn` low mid-run: outputs clear asynchronously.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU lane.
// Holds the register width, the largest chunk width, the funct6 opcodes and the
// vsew encodings. It also provides a helper that gives the number of chunks one
// lane owns.
package vec_alu_pkg;

    localparam int unsigned VLEN      = 128;
    localparam int unsigned CHUNK_MAX = 32;

    localparam logic [5:0] OP_VADD = 6'b000000;
    localparam logic [5:0] OP_VSUB = 6'b000010;
    localparam logic [5:0] OP_VAND = 6'b001001;
    localparam logic [5:0] OP_VOR  = 6'b001010;
    localparam logic [5:0] OP_VXOR = 6'b001011;

    localparam logic [2:0] SEW_8  = 3'b000;
    localparam logic [2:0] SEW_16 = 3'b001;
    localparam logic [2:0] SEW_32 = 3'b010;
    localparam logic [2:0] SEW_64 = 3'b011;

    // Number of chunks this lane processes. A reserved vsew still takes one
    // cycle, so that done rises.
    function automatic logic [4:0] lane_chunks(input logic [2:0] vsew, input logic [1:0] nb);
        logic [4:0] n;
        case (vsew)
            SEW_8:          n = 5'd16;
            SEW_16:         n = 5'd8;
            SEW_32, SEW_64: n = 5'd4;
            default:        n = 5'd0;
        endcase
        return vsew[2] ? 5'd1 : (n >> nb);
    endfunction

endpackage

// File: rtl/vec_alu_chunk.sv
// Combinational 32-bit ALU slice.
// Ports:
//   a, b      : chunk of vs2 and chunk of vs1 (the result is a op b)
//   opcode    : funct6 operation select
//   vsew      : element width; add and sub are segmented at element boundaries
//   carry_in  : carry injected into byte 0 (add-form carry, so 1 starts a subtract)
//   result    : slice result; unknown opcodes give zero
//   carry_out : carry out of byte 3
module vec_alu_chunk
    import vec_alu_pkg::*;
(
    input  logic [CHUNK_MAX-1:0] a,
    input  logic [CHUNK_MAX-1:0] b,
    input  logic [5:0]           opcode,
    input  logic [2:0]           vsew,
    input  logic                 carry_in,
    output logic [CHUNK_MAX-1:0] result,
    output logic                 carry_out
);

    logic                 sub;
    logic                 c;
    logic [7:0]           bb;
    logic [8:0]           s;
    logic [CHUNK_MAX-1:0] sum;

    // Subtract is computed as a + ~b + 1. Each element start re-injects the
    // "+1" (or 0 for add), so no carry crosses an element boundary.
    always_comb begin
        sub = (opcode == OP_VSUB);
        c   = carry_in;
        bb  = '0;
        s   = '0;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0 && (vsew == SEW_8 || (vsew == SEW_16 && k == 2))) begin
                c = sub;
            end
            bb = sub ? ~b[k*8 +: 8] : b[k*8 +: 8];
            s  = {1'b0, a[k*8 +: 8]} + {1'b0, bb} + {8'd0, c};
            sum[k*8 +: 8] = s[7:0];
            c  = s[8];
        end
        carry_out = c;
    end

    always_comb begin
        result = '0;
        case (opcode)
            OP_VADD, OP_VSUB: result = sum;
            OP_VAND:          result = a & b;
            OP_VOR:           result = a | b;
            OP_VXOR:          result = a ^ b;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/vec_alu_lane.sv
// Single-lane vector integer ALU slice with VLEN = 128.
// Each cycle in which run is high, the lane computes one chunk of
// op(vs2, vs1). The chunk width is min(SEW, 32). done rises once every chunk
// owned by this lane has been written to vd.
// Parameters:
//   NB_LANES : log2 of the lane count
//   LANE_I   : index of this lane
// Ports:
//   clk, resetn    : clock and asynchronous active-low reset
//   opcode         : funct6 operation select
//   run            : 1 = advance one chunk per cycle; 0 = clear and restart
//   vs1, vs2, vsew : source operands and element width
//   vd, done       : result register and completion flag
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter logic [1:0] NB_LANES = 2'b00,
    parameter logic [2:0] LANE_I   = 3'b000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [5:0]      opcode,
    input  logic            run,
    input  logic [VLEN-1:0] vs1,
    input  logic [VLEN-1:0] vs2,
    input  logic [2:0]      vsew,
    output logic [VLEN-1:0] vd,
    output logic            done
);

    logic [3:0]           cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic [VLEN-1:0]      vd_q, vd_d;
    logic                 done_q, done_d;

    logic [4:0]           m;
    logic [3:0]           j;
    logic [2:0]           elem;
    logic                 hi;
    logic [CHUNK_MAX-1:0] a, b, res;
    logic                 cin, cout;

    assign m = lane_chunks(vsew, NB_LANES);

    // Pick the global chunk index. For SEW=64, lanes own whole elements, and
    // each element is visited low half first and then high half.
    always_comb begin
        hi   = 1'b0;
        elem = '0;
        j    = {1'b0, LANE_I} + (cnt_q << NB_LANES);
        if (vsew == SEW_64) begin
            hi   = cnt_q[0];
            elem = LANE_I + (cnt_q[3:1] << NB_LANES);
            j    = {elem, hi};
        end
    end

    always_comb begin
        a = '0;
        b = '0;
        case (vsew)
            SEW_8: begin
                a = {24'd0, vs2[{j, 3'b000} +: 8]};
                b = {24'd0, vs1[{j, 3'b000} +: 8]};
            end
            SEW_16: begin
                a = {16'd0, vs2[{j[2:0], 4'b0000} +: 16]};
                b = {16'd0, vs1[{j[2:0], 4'b0000} +: 16]};
            end
            SEW_32, SEW_64: begin
                a = vs2[{j[1:0], 5'b00000} +: 32];
                b = vs1[{j[1:0], 5'b00000} +: 32];
            end
            default: ;
        endcase
        // The high half of a 64-bit element continues from the low half's
        // carry. Every other chunk starts a fresh element.
        cin = (vsew == SEW_64 && hi) ? carry_q : (opcode == OP_VSUB);
    end

    vec_alu_chunk u_chunk (
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .vsew      (vsew),
        .carry_in  (cin),
        .result    (res),
        .carry_out (cout)
    );

    always_comb begin
        vd_d    = vd_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        done_d  = done_q;
        if (!run) begin
            vd_d    = '0;
            cnt_d   = '0;
            carry_d = 1'b0;
            done_d  = 1'b0;
        end else if (!done_q) begin
            case (vsew)
                SEW_8:          vd_d[{j, 3'b000} +: 8]        = res[7:0];
                SEW_16:         vd_d[{j[2:0], 4'b0000} +: 16] = res[15:0];
                SEW_32, SEW_64: vd_d[{j[1:0], 5'b00000} +: 32] = res;
                default: ;
            endcase
            carry_d = (vsew == SEW_64 && !hi) ? cout : 1'b0;
            cnt_d   = cnt_q + 4'd1;
            done_d  = ({1'b0, cnt_q} + 5'd1) >= m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vd_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            vd_q    <= vd_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign vd   = vd_q;
    assign done = done_q;

endmodule

// File: tb/tb_vec_alu_lane.sv
module tb_vec_alu_lane;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         run = 1'b0;
    logic [5:0]   opcode = '0;
    logic [127:0] vs1 = '0;
    logic [127:0] vs2 = '0;
    logic [2:0]   vsew = '0;
    logic [127:0] vd, vd2;
    logic         done, done2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] V1  = 128'habcdabcdbeefbeef1234567887654321;
    localparam logic [127:0] V2  = 128'h8765432112345678beefbeefabcdabcd;
    localparam logic [127:0] EXP = 128'h83450301122416681224166883450301;

    vec_alu_lane dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .run(run),
        .vs1(vs1), .vs2(vs2), .vsew(vsew), .vd(vd), .done(done)
    );

    vec_alu_lane #(.NB_LANES(2'b01), .LANE_I(3'b001)) dut2 (
        .clk(clk), .resetn(resetn), .opcode(opcode), .run(run),
        .vs1(vs1), .vs2(vs2), .vsew(vsew), .vd(vd2), .done(done2)
    );

    always #5 clk = ~clk;

    // Reference model: element-wise arithmetic, then keep only the chunks this lane owns.
    function automatic logic [127:0] model_vd(input logic [5:0] op, input logic [127:0] a1,
                                              input logic [127:0] a2, input logic [2:0] sew,
                                              input int nb, input int lane);
        logic [127:0] res, keep;
        logic [63:0]  x, y, r, msk;
        int w, c, n, l, owner;
        res  = '0;
        keep = '0;
        if (sew[2]) return '0;
        w = 8 << sew;
        c = (w > 32) ? 32 : w;
        n = 128 / c;
        l = 1 << nb;
        msk = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        for (int e = 0; e < 128 / w; e++) begin
            x = 64'(a2 >> (e * w)) & msk;
            y = 64'(a1 >> (e * w)) & msk;
            case (op)
                6'b000000: r = x + y;
                6'b000010: r = x - y;
                6'b001001: r = x & y;
                6'b001010: r = x | y;
                6'b001011: r = x ^ y;
                default:   r = '0;
            endcase
            res |= 128'(r & msk) << (e * w);
        end
        for (int jj = 0; jj < n; jj++) begin
            owner = (w == 64) ? ((jj / 2) % l) : (jj % l);
            if (owner == lane) keep |= ((128'd1 << c) - 128'd1) << (jj * c);
        end
        return res & keep;
    endfunction

    function automatic int model_m(input logic [2:0] sew, input int nb);
        int n;
        if (sew[2]) return 1;
        n = (sew == 3'd0) ? 16 : (sew == 3'd1) ? 8 : 4;
        return n >> nb;
    endfunction

    // One run=0 edge with the operands applied, then leave run high.
    task automatic apply(input logic [5:0] op, input logic [127:0] a, input logic [127:0] b,
                         input logic [2:0] sew);
        opcode = op;
        vs1    = a;
        vs2    = b;
        vsew   = sew;
        run    = 1'b0;
        @(posedge clk);
        #1;
        run = 1'b1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (vd !== '0) begin n_fail++; $display("FAIL reset_vd: got %h expected 0", vd); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (done2 !== 1'b0 || vd2 !== '0) begin
            n_fail++; $display("FAIL reset_lane1: got %b/%h expected 0/0", done2, vd2);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_spec_vand();
        int m;
        for (int s = 0; s < 4; s++) begin
            apply(6'b001001, V1, V2, 3'(s));
            m = (s == 0) ? 16 : (s == 1) ? 8 : 4;
            for (int k = 1; k <= m; k++) begin
                edge_step();
                n_checks++;
                if (done !== (k == m)) begin
                    n_fail++;
                    $display("FAIL vand_done sew%0d edge %0d: got %b expected %b", s, k, done, k == m);
                end
            end
            n_checks++;
            if (vd !== EXP) begin n_fail++; $display("FAIL vand_vd sew%0d: got %h expected %h", s, vd, EXP); end
            edge_step();
            n_checks++;
            if (vd !== EXP || done !== 1'b1) begin
                n_fail++; $display("FAIL vand_hold sew%0d: got %b/%h expected 1/%h", s, done, vd, EXP);
            end
        end
    endtask

    task automatic test_carry();
        logic [127:0] e;
        apply(6'b000000, {16{8'h01}}, {16{8'hff}}, 3'd0);
        for (int k = 0; k < 16; k++) edge_step();
        n_checks++;
        if (vd !== '0 || done !== 1'b1) begin
            n_fail++; $display("FAIL add8_wrap: got %b/%h expected 1/0", done, vd);
        end

        apply(6'b000000, 128'h00000000ffffffff, 128'h1, 3'd3);
        for (int k = 0; k < 4; k++) edge_step();
        e = 128'h0000000100000000;
        n_checks++;
        if (vd !== e) begin n_fail++; $display("FAIL add64_carry: got %h expected %h", vd, e); end

        apply(6'b000010, 128'h1, 128'h0000000100000000, 3'd3);
        for (int k = 0; k < 4; k++) edge_step();
        e = 128'h00000000ffffffff;
        n_checks++;
        if (vd !== e) begin n_fail++; $display("FAIL sub64_borrow: got %h expected %h", vd, e); end

        apply(6'b000000, 128'h0000000000000005ffffffffffffffff,
              128'h00000000000000030000000000000001, 3'd3);
        for (int k = 0; k < 4; k++) edge_step();
        e = 128'h00000000000000080000000000000000;
        n_checks++;
        if (vd !== e) begin n_fail++; $display("FAIL add64_elem_boundary: got %h expected %h", vd, e); end
    endtask

    task automatic test_multilane();
        logic [127:0] e;
        e = 128'h83450301000000001224166800000000;
        apply(6'b001001, V1, V2, 3'd2);
        for (int k = 1; k <= 3; k++) begin
            edge_step();
            n_checks++;
            if (done2 !== (k >= 2)) begin
                n_fail++; $display("FAIL lane1_done edge %0d: got %b expected %b", k, done2, k >= 2);
            end
        end
        n_checks++;
        if (vd2 !== e) begin n_fail++; $display("FAIL lane1_vd: got %h expected %h", vd2, e); end
    endtask

    task automatic test_random();
        logic [5:0]   ops [6];
        logic [5:0]   op;
        logic [127:0] a, b, e1, e2;
        logic [2:0]   sew;
        int           m1, m2, mx, r;
        ops = '{6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b001011, 6'b011000};
        for (int it = 0; it < 40; it++) begin
            op = ops[$urandom_range(0, 5)];
            a  = {$urandom, $urandom, $urandom, $urandom};
            b  = {$urandom, $urandom, $urandom, $urandom};
            r  = $urandom_range(0, 4);
            sew = (r == 4) ? (3'b100 | 3'($urandom_range(0, 3))) : 3'(r);
            e1 = model_vd(op, a, b, sew, 0, 0);
            e2 = model_vd(op, a, b, sew, 1, 1);
            m1 = model_m(sew, 0);
            m2 = model_m(sew, 1);
            mx = m1 + 1;
            apply(op, a, b, sew);
            for (int k = 1; k <= mx; k++) begin
                edge_step();
                n_checks++;
                if (done !== (k >= m1)) begin
                    n_fail++;
                    $display("FAIL rand_done it%0d edge %0d: got %b expected %b", it, k, done, k >= m1);
                end
                if (sew != 3'd3) begin
                    n_checks++;
                    if (done2 !== (k >= m2)) begin
                        n_fail++;
                        $display("FAIL rand_done2 it%0d edge %0d: got %b expected %b", it, k, done2, k >= m2);
                    end
                end
            end
            n_checks++;
            if (vd !== e1) begin
                n_fail++; $display("FAIL rand_vd it%0d op %b sew %b: got %h expected %h", it, op, sew, vd, e1);
            end
            if (sew != 3'd3) begin
                n_checks++;
                if (vd2 !== e2) begin
                    n_fail++; $display("FAIL rand_vd2 it%0d op %b sew %b: got %h expected %h", it, op, sew, vd2, e2);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [127:0] e;
        e = EXP & ((128'd1 << 40) - 128'd1);
        apply(6'b001001, V1, V2, 3'd0);
        for (int k = 0; k < 5; k++) edge_step();
        n_checks++;
        if (vd !== e || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_partial: got %b/%h expected 0/%h", done, vd, e);
        end
        run = 1'b0;
        edge_step();
        n_checks++;
        if (vd !== '0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_clear: got %b/%h expected 0/0", done, vd);
        end
    endtask

    task automatic test_async_reset();
        apply(6'b001001, V1, V2, 3'd0);
        for (int k = 0; k < 3; k++) edge_step();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (vd !== '0 || done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %b/%h expected 0/0", done, vd);
        end
        n_checks++;
        if (vd2 !== '0 || done2 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_lane1: got %b/%h expected 0/0", done2, vd2);
        end
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_spec_vand();
        test_carry();
        test_multilane();
        test_random();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
